disparo_inimigo: RTL
====================

DISPARO_INIMIGO -- requirements
Module: disparo_inimigo

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SIZE_ENEMY, 10: number of enemies.
- TICK_DIV, 500000: clock cycles per movement step.
- VEL, 4: pixels moved down per step.
- RAIO, 5: enemy ball radius.
- Y_LIMITE, 480: screen bottom.
- COOLDOWN, 30: steps between shots.
- VIDAS_INICIAIS, 3: ship lives at start.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- CLOCK_50, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- pausa, in, 1: freeze.
- reiniciarJogo, in, 1: synchronous restart.
- x_inimigo, in, 10*SIZE_ENEMY: enemy i at bits [10i+9:10i].
- y_inimigo, in, 10*SIZE_ENEMY: same packing as x_inimigo.
- vidas_inimigo, in, SIZE_ENEMY: 1 = enemy alive.
- largura_inimigo, in, 10: enemy width.
- altura_inimigo, in, 10: enemy height.
- x_nave, in, 10: ship top-left x.
- y_nave, in, 10: ship top-left y.
- largura_nave, in, 10: ship width.
- altura_nave, in, 10: ship height.
- x_bola_inimiga, out, 10: enemy ball x.
- y_bola_inimiga, out, 10: enemy ball y.
- raio_bola_inimiga, out, 10: enemy ball radius.
- ativa, out, 1: ball in flight.
- acertou, out, 1: one-cycle ship-hit pulse.
- vidas_nave, out, 2: ship lives remaining.
- fim_de_jogo, out, 1: game over.

Function
REQ-003 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for one cycle when count = TICK_DIV-1.
REQ-004 An 8-bit LFSR SHALL use taps x^8+x^6+x^5+x^4+1 and seed 8'hA5, and SHALL advance every cycle, including during pausa.
REQ-005 The FSM SHALL have states ESPERA, ESCOLHE, VOANDO and FIM.
REQ-006 ESPERA: a cooldown counter SHALL decrement on each tick. On the tick where it reaches 0, the FSM SHALL go to ESCOLHE and latch idx = lfsr mod SIZE_ENEMY.
REQ-007 ESCOLHE: the FSM SHALL test one enemy per cycle.
- If vidas_inimigo[idx]=1: spawn and go to VOANDO.
- Otherwise: idx = (idx+1) mod SIZE_ENEMY.
- After SIZE_ENEMY failed tests: go to ESPERA with cooldown reloaded to COOLDOWN.
REQ-008 Spawn position SHALL be x = x_inimigo[idx] + largura_inimigo/2 (integer divide) and y = y_inimigo[idx] + altura_inimigo, both truncated to 10 bits.
REQ-009 VOANDO: y SHALL increase by VEL on each tick; x SHALL stay constant.
REQ-010 Hit SHALL be evaluated every VOANDO cycle with 11-bit unsigned arithmetic. Hit is true when all of:
- x >= x_nave
- x < x_nave + largura_nave
- y + RAIO >= y_nave
- y < y_nave + altura_nave
REQ-011 On hit, the block SHALL:
- pulse acertou for exactly one cycle;
- decrement vidas_nave;
- go to FIM if the new value is 0, else to ESPERA with cooldown reloaded.
REQ-012 If no hit and y + RAIO >= Y_LIMITE, the FSM SHALL go to ESPERA with cooldown reloaded and no acertou pulse.
REQ-013 If hit and off-screen are both true in the same cycle, the hit SHALL win.
REQ-014 ativa SHALL be 1 only in VOANDO. Outside VOANDO, x_bola_inimiga and y_bola_inimiga SHALL be 0.
REQ-015 raio_bola_inimiga SHALL equal RAIO at all times.
REQ-016 FIM: fim_de_jogo SHALL be 1 and ativa SHALL be 0. FIM SHALL be left only by reset or reiniciarJogo.
REQ-017 pausa=1 SHALL freeze the prescaler, the cooldown counter, the FSM, position and hit evaluation; all outputs SHALL hold their values.
REQ-018 vidas_nave SHALL never underflow below 0.
REQ-019 Changes to vidas_inimigo during VOANDO SHALL NOT cancel the ball already in flight.

Reset
REQ-020 While reset=0, the block SHALL asynchronously force:
- state = ESPERA, cooldown = COOLDOWN, prescaler = 0, lfsr = 8'hA5;
- x = y = 0, ativa = 0, acertou = 0, fim_de_jogo = 0;
- vidas_nave = VIDAS_INICIAIS.
REQ-021 reiniciarJogo=1 SHALL apply the same values on the next clock edge, except the LFSR, and SHALL take priority over pausa. This holds in any state, including mid-flight.

Verification
(Parameters for all scenarios: TICK_DIV=2, COOLDOWN=2, VEL=4, RAIO=5, Y_LIMITE=480.)
REQ-022 Spawn: all enemies alive; enemy 3 at (100,100); largura_inimigo=20, altura_inimigo=16; force idx=3 -> ball at (110,116) with ativa=1, then y=120 after one tick.
REQ-023 Miss: ship at (300,400), ball at x=110 -> reaches y+5 >= 480, ativa drops, acertou stays 0, vidas_nave=3.
REQ-024 Hit: ship at (100,130), size 30x10 -> acertou one-cycle pulse when y+5 >= 130, vidas_nave 3->2, state ESPERA.
REQ-025 Game over: three consecutive hits -> vidas_nave=0, fim_de_jogo=1, no further shots. reiniciarJogo=1 -> vidas_nave=3, fim_de_jogo=0.
REQ-026 No enemies: vidas_inimigo=0 -> ESCOLHE returns to ESPERA after 10 cycles, ativa never 1.
REQ-027 Pause and reset: pausa=1 mid-flight for 50 cycles -> y unchanged. Asserting reset=0 mid-flight -> ativa=0 and vidas_nave=3 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/disparo_inimigo.sv
// disparo_inimigo: enemy shot controller.
// Every COOLDOWN movement steps, a pseudo-random living enemy fires one ball
// straight down. A ball that overlaps the ship costs one life. The ball is
// dropped when it leaves the screen. When the last life is lost, the block
// parks in game over until it is reset or restarted.
// Ports:
//   CLOCK_50, reset (async, active-low), pausa (freeze), reiniciarJogo (sync restart)
//   x_inimigo/y_inimigo   : packed enemy positions, 10 bits per enemy
//   vidas_inimigo         : per-enemy alive flags
//   largura/altura_inimigo: enemy size
//   x/y/largura/altura_nave: ship box
//   x/y/raio_bola_inimiga : ball position and radius
//   ativa                 : ball in flight
//   acertou               : one-cycle pulse when the ship is hit
//   vidas_nave            : ship lives left
//   fim_de_jogo           : game over
module disparo_inimigo #(
    parameter int SIZE_ENEMY     = 10,
    parameter int TICK_DIV       = 500000,
    parameter int VEL            = 4,
    parameter int RAIO           = 5,
    parameter int Y_LIMITE       = 480,
    parameter int COOLDOWN       = 30,
    parameter int VIDAS_INICIAIS = 3
) (
    input  logic                       CLOCK_50,
    input  logic                       reset,
    input  logic                       pausa,
    input  logic                       reiniciarJogo,
    input  logic [10*SIZE_ENEMY-1:0]   x_inimigo,
    input  logic [10*SIZE_ENEMY-1:0]   y_inimigo,
    input  logic [SIZE_ENEMY-1:0]      vidas_inimigo,
    input  logic [9:0]                 largura_inimigo,
    input  logic [9:0]                 altura_inimigo,
    input  logic [9:0]                 x_nave,
    input  logic [9:0]                 y_nave,
    input  logic [9:0]                 largura_nave,
    input  logic [9:0]                 altura_nave,
    output logic [9:0]                 x_bola_inimiga,
    output logic [9:0]                 y_bola_inimiga,
    output logic [9:0]                 raio_bola_inimiga,
    output logic                       ativa,
    output logic                       acertou,
    output logic [1:0]                 vidas_nave,
    output logic                       fim_de_jogo
);

    localparam int IW = (SIZE_ENEMY > 1) ? $clog2(SIZE_ENEMY) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(COOLDOWN + 1) > 0 ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {ESPERA, ESCOLHE, VOANDO, FIM} estado_t;

    estado_t         state, next_state;
    logic [PW-1:0]   presc;
    logic [7:0]      lfsr;
    logic [CW-1:0]   cooldown;
    logic [IW-1:0]   idx, tries;
    logic [9:0]      x_r, y_r;
    logic            acertou_r;
    logic [1:0]      vidas_r;

    logic            tick;
    logic            vivo;
    logic            ultima_tentativa;
    logic [IW-1:0]   idx_inc, idx_lfsr;
    logic [9:0]      spawn_x, spawn_y;
    logic [10:0]     bx, by, nx, ny, nl, na;
    logic            hit, fora;

    assign tick             = (presc == PW'(TICK_DIV - 1));
    assign vivo             = vidas_inimigo[idx];
    assign ultima_tentativa = (tries == IW'(SIZE_ENEMY - 1));
    assign idx_inc          = (idx == IW'(SIZE_ENEMY - 1)) ? '0 : idx + 1'b1;
    assign idx_lfsr         = IW'(int'(lfsr) % SIZE_ENEMY);
    assign spawn_x          = x_inimigo[int'(idx)*10 +: 10] + (largura_inimigo >> 1);
    assign spawn_y          = y_inimigo[int'(idx)*10 +: 10] + altura_inimigo;

    // Collision math is 11 bits wide so box edges near 1023 do not wrap.
    assign bx   = {1'b0, x_r};
    assign by   = {1'b0, y_r};
    assign nx   = {1'b0, x_nave};
    assign ny   = {1'b0, y_nave};
    assign nl   = {1'b0, largura_nave};
    assign na   = {1'b0, altura_nave};
    assign hit  = (bx >= nx) && (bx < nx + nl) &&
                  (by + 11'(RAIO) >= ny) && (by < ny + na);
    assign fora = (by + 11'(RAIO) >= 11'(Y_LIMITE));

    // State register
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset)
            state <= ESPERA;
        else
            state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (reiniciarJogo) begin
            next_state = ESPERA;
        end else if (!pausa) begin
            unique case (state)
                ESPERA:  if (tick && cooldown <= CW'(1)) next_state = ESCOLHE;
                ESCOLHE: begin
                    if (vivo)                  next_state = VOANDO;
                    else if (ultima_tentativa) next_state = ESPERA;
                end
                VOANDO: begin
                    // A hit takes precedence over leaving the screen.
                    if (hit)       next_state = (vidas_r <= 2'd1) ? FIM : ESPERA;
                    else if (fora) next_state = ESPERA;
                end
                FIM:     next_state = FIM;
                default: next_state = ESPERA;
            endcase
        end
    end

    // Datapath: prescaler, cooldown, enemy scan, ball position, lives
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            presc     <= '0;
            lfsr      <= 8'hA5;
            cooldown  <= CW'(COOLDOWN);
            idx       <= '0;
            tries     <= '0;
            x_r       <= '0;
            y_r       <= '0;
            acertou_r <= 1'b0;
            vidas_r   <= 2'(VIDAS_INICIAIS);
        end else begin
            // The LFSR free-runs regardless of pause or restart.
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (reiniciarJogo) begin
                presc     <= '0;
                cooldown  <= CW'(COOLDOWN);
                idx       <= '0;
                tries     <= '0;
                x_r       <= '0;
                y_r       <= '0;
                acertou_r <= 1'b0;
                vidas_r   <= 2'(VIDAS_INICIAIS);
            end else if (!pausa) begin
                presc     <= tick ? '0 : presc + 1'b1;
                acertou_r <= 1'b0;
                unique case (state)
                    ESPERA: begin
                        if (tick) begin
                            if (cooldown <= CW'(1)) begin
                                cooldown <= '0;
                                idx      <= idx_lfsr;
                                tries    <= '0;
                            end else begin
                                cooldown <= cooldown - 1'b1;
                            end
                        end
                    end
                    ESCOLHE: begin
                        if (vivo) begin
                            x_r <= spawn_x;
                            y_r <= spawn_y;
                        end else begin
                            idx   <= idx_inc;
                            tries <= tries + 1'b1;
                            if (ultima_tentativa) cooldown <= CW'(COOLDOWN);
                        end
                    end
                    VOANDO: begin
                        if (hit) begin
                            acertou_r <= 1'b1;
                            vidas_r   <= (vidas_r != 2'd0) ? vidas_r - 2'd1 : 2'd0;
                            cooldown  <= CW'(COOLDOWN);
                            x_r       <= '0;
                            y_r       <= '0;
                        end else if (fora) begin
                            cooldown  <= CW'(COOLDOWN);
                            x_r       <= '0;
                            y_r       <= '0;
                        end else if (tick) begin
                            y_r <= y_r + 10'(VEL);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs
    always_comb begin
        ativa             = (state == VOANDO);
        fim_de_jogo       = (state == FIM);
        x_bola_inimiga    = (state == VOANDO) ? x_r : '0;
        y_bola_inimiga    = (state == VOANDO) ? y_r : '0;
        raio_bola_inimiga = 10'(RAIO);
        acertou           = acertou_r;
        vidas_nave        = vidas_r;
    end

endmodule
